line_draw_arbiter: RTL and testbench
====================================

Name: line_draw_arbiter

Overview:
Shares one line_drawer instance among NUM_REQ independent line requesters, such as several animators or overlay sources, using round-robin arbitration. For each granted request it latches the endpoints and colour, sequences the drawer's reset/start, and streams the resulting pixels to the framebuffer write port. When the line is finished it acknowledges the requester. It sits between the animation controllers and the single drawer/framebuffer path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
COORD_W, 11, coordinate width in bits; matches line_drawer

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester line request; held high with stable data until ack
req_x0  input  NUM_REQ*COORD_W  start x, requester i in bits [i*COORD_W +: COORD_W]
req_y0  input  NUM_REQ*COORD_W  start y, same packing
req_x1  input  NUM_REQ*COORD_W  end x, same packing
req_y1  input  NUM_REQ*COORD_W  end y, same packing
req_color  input  NUM_REQ  pixel colour per requester (1 = white, 0 = black)
ack  output  NUM_REQ  one-hot, one-cycle pulse: requester's line fully emitted
busy  output  1  high in every state except IDLE
grant_id  output  $clog2(NUM_REQ)  index of the currently or last served requester
drw_reset  output  1  reset/start to line_drawer
drw_x0, drw_y0, drw_x1, drw_y1  output  COORD_W each  latched endpoints to line_drawer
drw_x, drw_y  input  COORD_W each  current drawer pixel
drw_finished  input  1  drawer's current pixel is the endpoint
x, y  output  COORD_W each  pixel coordinate to framebuffer (= drw_x/drw_y)
pixel_color  output  1  latched colour of the current line
pixel_valid  output  1  write-enable for (x, y, pixel_color)

Behaviour:
- Drawer contract: while drw_reset=1 the drawer loads its endpoints. In the first cycle after drw_reset drops, drw_x/drw_y = (x0, y0). It advances one pixel per cycle. drw_finished=1 in the cycle the endpoint is presented and stays high. Endpoints must stay stable until the drawer is reset again.
- FSM states: IDLE, START, DRAW, ACK.
- IDLE: if any req bit is set, pick the first set bit searching upward from ptr with wrap-around. Latch that requester's endpoints, colour and index into drw_*/pixel_color/grant_id, then go to START. Otherwise stay in IDLE.
- START: drw_reset=1, pixel_valid=0; go to DRAW.
- DRAW: pixel_valid=1. If drw_finished, this cycle carries the final pixel; go to ACK.
- ACK: ack[grant_id]=1 for exactly one cycle; ptr <= (grant_id+1) mod NUM_REQ; go to IDLE.
- drw_reset = reset OR (state==START).
- Latency: for a line of P pixels with req already high in IDLE:
  - IDLE at cycle c, START at c+1, pixels at c+2 .. c+1+P, ACK at c+2+P.
  - Next grant decision at c+3+P.
- Requesters clear req at the clock edge on which they see ack=1. A req still high in the following IDLE cycle is treated as a new request.
- Inputs from non-granted requesters are ignored while busy. Changing the granted requester's req_* data mid-line has no effect because the data is latched.
- Only IDLE samples req. A req that drops before it is granted is simply not served. A req that drops mid-line is ignored and the line still completes and is acked.
- Single-point line (x0=x1, y0=y1): drw_finished is high in the first DRAW cycle, so P=1.
- Reset, including mid-line:
  - Next cycle: state=IDLE, ptr=0, ack=0, pixel_valid=0, busy=0, grant_id=0, drw_x0/y0/x1/y1=0, pixel_color=0.
  - The in-flight line is abandoned and never acked.
- pixel_valid=0 in IDLE, START and ACK. x/y mirror drw_x/drw_y in all states but are only meaningful while pixel_valid=1.

Test Plan:
- Single request: req=0001, requester 0 line (0,0)->(3,3), colour 1 → pixel_valid high 4 cycles at (0,0),(1,1),(2,2),(3,3) with colour 1; ack=0001 one cycle later; busy low afterward.
- Round-robin: req=1111 held, each requester re-asserting after its ack → grant_id sequence 0,1,2,3,0; no requester served twice before all others are served once.
- Priority pointer: after serving 1, assert req=0011 → requester 0 is skipped in favour of... no, search starts at 2 and wraps, so grant 0; then with req=0011 again, grant 1.
- Single-point line: requester 2 line (5,7)->(5,7) → exactly one pixel_valid cycle at (5,7); ack=0100 on the next cycle; total 4 cycles from IDLE to ACK.
- Data change mid-line: alter req_x1 of the granted requester during DRAW → emitted pixels still match the latched endpoints.
- Reset mid-line: assert reset during the 3rd pixel of a 10-pixel line → pixel_valid=0 and ack=0 the next cycle; re-request with req=0010 is served from ptr=0 and its line restarts from the start point.

Source files
------------

// File: rtl/line_draw_arbiter_if.sv
// Requester-side bus of the line draw arbiter: per-requester line
// requests with packed endpoints and colour, and the one-hot ack back.
interface line_draw_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int COORD_W = 11
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*COORD_W-1:0] req_x0;
    logic [NUM_REQ*COORD_W-1:0] req_y0;
    logic [NUM_REQ*COORD_W-1:0] req_x1;
    logic [NUM_REQ*COORD_W-1:0] req_y1;
    logic [NUM_REQ-1:0]         req_color;
    logic [NUM_REQ-1:0]         ack;

    // Requesters drive the line descriptions and observe the ack pulse.
    modport master (
        output req, req_x0, req_y0, req_x1, req_y1, req_color,
        input  ack
    );

    // The arbiter samples the line descriptions and drives the ack pulse.
    modport slave (
        input  req, req_x0, req_y0, req_x1, req_y1, req_color,
        output ack
    );
endinterface

// File: rtl/line_draw_arbiter.sv
// Round-robin arbiter sharing one line_drawer between NUM_REQ requesters.
// A granted request has its endpoints and colour latched, the drawer is
// restarted, every drawer pixel is forwarded to the framebuffer port and
// the requester receives a one-cycle ack after the final pixel.
module line_draw_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int COORD_W = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    line_draw_arbiter_if.slave         req_if,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       drw_reset,
    output logic [COORD_W-1:0]         drw_x0,
    output logic [COORD_W-1:0]         drw_y0,
    output logic [COORD_W-1:0]         drw_x1,
    output logic [COORD_W-1:0]         drw_y1,
    input  logic [COORD_W-1:0]         drw_x,
    input  logic [COORD_W-1:0]         drw_y,
    input  logic                       drw_finished,
    output logic [COORD_W-1:0]         x,
    output logic [COORD_W-1:0]         y,
    output logic                       pixel_color,
    output logic                       pixel_valid
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAW  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [COORD_W-1:0]  drw_x0_q, drw_x0_d;
    logic [COORD_W-1:0]  drw_y0_q, drw_y0_d;
    logic [COORD_W-1:0]  drw_x1_q, drw_x1_d;
    logic [COORD_W-1:0]  drw_y1_q, drw_y1_d;
    logic                pixel_color_q, pixel_color_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic                busy_q, busy_d;

    logic                sel_found;
    logic [ID_W-1:0]     sel_idx;

    // Round-robin search: first set req bit at or above ptr, wrapping around.
    always_comb begin
        int idx;
        // NOTE: every variable assigned here gets a default first so the
        // block can never infer a latch on a path that skips an assignment.
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!sel_found && req_if.req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(idx);
            end
        end
    end

    // Next-state logic: grant and latch in IDLE, sequence the drawer, ack.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        drw_x0_d      = drw_x0_q;
        drw_y0_d      = drw_y0_q;
        drw_x1_d      = drw_x1_q;
        drw_y1_d      = drw_y1_q;
        pixel_color_d = pixel_color_q;

        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_id_d    = sel_idx;
                    drw_x0_d      = req_if.req_x0[int'(sel_idx)*COORD_W +: COORD_W];
                    drw_y0_d      = req_if.req_y0[int'(sel_idx)*COORD_W +: COORD_W];
                    drw_x1_d      = req_if.req_x1[int'(sel_idx)*COORD_W +: COORD_W];
                    drw_y1_d      = req_if.req_y1[int'(sel_idx)*COORD_W +: COORD_W];
                    pixel_color_d = req_if.req_color[sel_idx];
                    state_d       = START;
                end
            end
            START: state_d = DRAW;
            DRAW: begin
                // The cycle with drw_finished still carries the final pixel.
                if (drw_finished) state_d = ACK;
            end
            ACK: begin
                ptr_d   = (int'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered, so decode them from the next state.
        pixel_valid_d = (state_d == DRAW);
        busy_d        = (state_d != IDLE);
        ack_d         = '0;
        if (state_d == ACK) ack_d[grant_id_d] = 1'b1;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            drw_x0_q      <= '0;
            drw_y0_q      <= '0;
            drw_x1_q      <= '0;
            drw_y1_q      <= '0;
            pixel_color_q <= 1'b0;
            ack_q         <= '0;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            drw_x0_q      <= drw_x0_d;
            drw_y0_q      <= drw_y0_d;
            drw_x1_q      <= drw_x1_d;
            drw_y1_q      <= drw_y1_d;
            pixel_color_q <= pixel_color_d;
            ack_q         <= ack_d;
            pixel_valid_q <= pixel_valid_d;
            busy_q        <= busy_d;
        end
    end

    // The drawer is held in reset whenever the system is, and restarted in START.
    assign drw_reset   = reset | (state_q == START);
    assign drw_x0      = drw_x0_q;
    assign drw_y0      = drw_y0_q;
    assign drw_x1      = drw_x1_q;
    assign drw_y1      = drw_y1_q;
    assign grant_id    = grant_id_q;
    assign pixel_color = pixel_color_q;
    assign pixel_valid = pixel_valid_q;
    assign busy        = busy_q;
    assign req_if.ack  = ack_q;
    assign x           = drw_x;
    assign y           = drw_y;
endmodule

// File: tb/tb_line_draw_arbiter.sv
// Directed bench for line_draw_arbiter with a simple stepping line_drawer
// stand-in (moves x and y one unit per cycle toward the end point).
module tb_line_draw_arbiter;
    localparam int NUM_REQ = 4;
    localparam int COORD_W = 11;

    logic               clk = 1'b0;
    logic               reset;
    logic               busy;
    logic [1:0]         grant_id;
    logic               drw_reset;
    logic [COORD_W-1:0] drw_x0, drw_y0, drw_x1, drw_y1;
    logic [COORD_W-1:0] drw_x, drw_y;
    logic               drw_finished;
    logic [COORD_W-1:0] x, y;
    logic               pixel_color;
    logic               pixel_valid;

    int checks   = 0;
    int failures = 0;

    line_draw_arbiter_if #(.NUM_REQ(NUM_REQ), .COORD_W(COORD_W)) rif ();

    line_draw_arbiter #(.NUM_REQ(NUM_REQ), .COORD_W(COORD_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_if       (rif),
        .busy         (busy),
        .grant_id     (grant_id),
        .drw_reset    (drw_reset),
        .drw_x0       (drw_x0),
        .drw_y0       (drw_y0),
        .drw_x1       (drw_x1),
        .drw_y1       (drw_y1),
        .drw_x        (drw_x),
        .drw_y        (drw_y),
        .drw_finished (drw_finished),
        .x            (x),
        .y            (y),
        .pixel_color  (pixel_color),
        .pixel_valid  (pixel_valid)
    );

    always #5 clk = ~clk;

    // Drawer stand-in: load start point during reset, then step toward end.
    always @(posedge clk) begin
        if (drw_reset) begin
            drw_x <= drw_x0;
            drw_y <= drw_y0;
        end else begin
            if (drw_x < drw_x1) drw_x <= drw_x + 11'd1;
            else if (drw_x > drw_x1) drw_x <= drw_x - 11'd1;
            if (drw_y < drw_y1) drw_y <= drw_y + 11'd1;
            else if (drw_y > drw_y1) drw_y <= drw_y - 11'd1;
        end
    end
    assign drw_finished = (drw_x == drw_x1) && (drw_y == drw_y1);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic set_line(input int i, input int x0, input int y0, input int x1, input int y1, input logic c);
        rif.req_x0[i*COORD_W +: COORD_W] = COORD_W'(x0);
        rif.req_y0[i*COORD_W +: COORD_W] = COORD_W'(y0);
        rif.req_x1[i*COORD_W +: COORD_W] = COORD_W'(x1);
        rif.req_y1[i*COORD_W +: COORD_W] = COORD_W'(y1);
        rif.req_color[i] = c;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Run until an ack appears (bounded); returns at the ack cycle's negedge.
    task automatic serve(input string tag, input int exp_id, input int exp_pix, input int exp_x0);
        int  npix = 0;
        int  fx   = -1;
        bit  got  = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (pixel_valid) begin
                if (npix == 0) fx = int'(x);
                npix++;
            end
            if (rif.ack != '0) got = 1'b1;
        end
        check({tag, "_ack"},     32'(rif.ack),  32'(1 << exp_id));
        check({tag, "_grant"},   32'(grant_id), 32'(exp_id));
        check({tag, "_npix"},    32'(npix),     32'(exp_pix));
        check({tag, "_first_x"}, 32'(fx),       32'(exp_x0));
    endtask

    initial begin
        reset         = 1'b1;
        rif.req       = '0;
        rif.req_x0    = '0;
        rif.req_y0    = '0;
        rif.req_x1    = '0;
        rif.req_y1    = '0;
        rif.req_color = '0;

        // Reset state.
        step(); step();
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_ack",       32'(rif.ack),     32'd0);
        check("rst_pv",        32'(pixel_valid), 32'd0);
        check("rst_grant",     32'(grant_id),    32'd0);
        check("rst_drw_reset", 32'(drw_reset),   32'd1);
        check("rst_drw_x0",    32'(drw_x0),      32'd0);

        // Single request (0,0)->(3,3) colour 1, with mid-line change of x1.
        reset = 1'b0;
        set_line(0, 0, 0, 3, 3, 1'b1);
        rif.req = 4'b0001;
        step();
        check("t1_start_busy",  32'(busy),        32'd1);
        check("t1_start_pv",    32'(pixel_valid), 32'd0);
        check("t1_start_drst",  32'(drw_reset),   32'd1);
        check("t1_start_grant", 32'(grant_id),    32'd0);
        check("t1_start_x1",    32'(drw_x1),      32'd3);
        for (int p = 0; p < 4; p++) begin
            step();
            check("t1_pv",    32'(pixel_valid), 32'd1);
            check("t1_x",     32'(x),           32'(p));
            check("t1_y",     32'(y),           32'(p));
            check("t1_color", 32'(pixel_color), 32'd1);
            check("t1_ack0",  32'(rif.ack),     32'd0);
            if (p == 1) set_line(0, 0, 0, 9, 3, 1'b1);
        end
        check("t1_latched_x1", 32'(drw_x1), 32'd3);
        step();
        check("t1_ack",      32'(rif.ack),     32'b0001);
        check("t1_ack_pv",   32'(pixel_valid), 32'd0);
        check("t1_ack_busy", 32'(busy),        32'd1);
        rif.req = '0;
        step();
        check("t1_idle_busy", 32'(busy),    32'd0);
        check("t1_idle_ack",  32'(rif.ack), 32'd0);

        // Round-robin with all four held; reset first so ptr starts at 0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_line(i, i, 0, i + 1, 0, 1'b0);
        rif.req = 4'b1111;
        serve("rr0", 0, 2, 0);
        serve("rr1", 1, 2, 1);
        serve("rr2", 2, 2, 2);
        serve("rr3", 3, 2, 3);
        serve("rr4", 0, 2, 0);

        // Priority pointer: serve 1, then 0011 wraps to 0, then 0011 gives 1.
        rif.req = 4'b0010;
        serve("pp1", 1, 2, 1);
        rif.req = 4'b0011;
        serve("pp2", 0, 2, 0);
        serve("pp3", 1, 2, 1);
        rif.req = '0;
        step();
        check("pp_idle_busy", 32'(busy), 32'd0);

        // Single-point line (5,7)->(5,7) from requester 2.
        set_line(2, 5, 7, 5, 7, 1'b1);
        rif.req = 4'b0100;
        step();
        check("sp_start_pv",    32'(pixel_valid), 32'd0);
        check("sp_start_grant", 32'(grant_id),    32'd2);
        step();
        check("sp_pv",    32'(pixel_valid),  32'd1);
        check("sp_x",     32'(x),            32'd5);
        check("sp_y",     32'(y),            32'd7);
        check("sp_fin",   32'(drw_finished), 32'd1);
        step();
        check("sp_ack",    32'(rif.ack),     32'b0100);
        check("sp_ack_pv", 32'(pixel_valid), 32'd0);
        rif.req = '0;
        step();
        check("sp_idle_busy", 32'(busy),    32'd0);
        check("sp_idle_ack",  32'(rif.ack), 32'd0);

        // Reset during the 3rd pixel of a 10-pixel line from requester 1.
        set_line(1, 0, 0, 9, 0, 1'b1);
        set_line(3, 4, 4, 6, 4, 1'b1);
        rif.req = 4'b0010;
        step();
        check("mr_grant", 32'(grant_id), 32'd1);
        step(); step(); step();
        check("mr_pv3", 32'(pixel_valid), 32'd1);
        check("mr_x3",  32'(x),           32'd2);
        reset = 1'b1;
        step();
        check("mr_pv",    32'(pixel_valid), 32'd0);
        check("mr_ack",   32'(rif.ack),     32'd0);
        check("mr_busy",  32'(busy),        32'd0);
        check("mr_grant0",32'(grant_id),    32'd0);
        check("mr_x1",    32'(drw_x1),      32'd0);
        check("mr_color", 32'(pixel_color), 32'd0);
        reset   = 1'b0;
        rif.req = 4'b1010;
        step();
        check("mr_regrant", 32'(grant_id), 32'd1);
        check("mr_re_x1",   32'(drw_x1),   32'd9);
        serve("mr_line", 1, 10, 0);
        rif.req = '0;
        step();
        check("mr_end_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
